// File: rtl/dmem_arbiter_if.sv
// Bus bundle between CPU MEM stage, external requester and data memory.
// slave: arbiter view; master: requester/memory-side (bench) view.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;

  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [15:0] ext_wdata;
  logic        ext_gnt;
  logic        ext_rvalid;
  logic [15:0] ext_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one 16-bit data memory between CPU and an external port.
// Ports: clk_i, rst_i (sync, active-high), bus (dmem_arbiter_if.slave).
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT  = 3,
  parameter int unsigned EXT_MAX_BURST = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {
    PRI_CPU = 1'b0,
    PRI_EXT = 1'b1
  } pri_e;

  localparam logic [3:0] SL = 4'(STARVE_LIMIT);
  localparam logic [3:0] MB = 4'(EXT_MAX_BURST);

  pri_e        state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [3:0]  burst_q, burst_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_owner_q, rd_owner_d;
  logic [15:0] cpu_hold_q, cpu_hold_d;
  logic [15:0] ext_hold_q, ext_hold_d;

  logic        cpu_gnt;
  logic        ext_gnt;
  logic        cpu_rv;
  logic        ext_rv;
  logic        ext_starved;

  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (!rst_i) begin
      if (bus.cpu_req && bus.ext_req) begin
        cpu_gnt = (state_q == PRI_CPU);
        ext_gnt = (state_q == PRI_EXT);
      end else begin
        cpu_gnt = bus.cpu_req;
        ext_gnt = bus.ext_req;
      end
    end
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 16'h0;
    bus.mem_wdata = 16'h0;
    unique case (1'b1)
      cpu_gnt: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.cpu_we;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
      end
      ext_gnt: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.ext_we;
        bus.mem_addr  = bus.ext_addr;
        bus.mem_wdata = bus.ext_wdata;
      end
      default: ;
    endcase
  end

  assign ext_starved = bus.ext_req && !ext_gnt;

  always_comb begin
    wait_d  = 4'd0;
    state_d = state_q;
    burst_d = burst_q;
    if (ext_starved)
      wait_d = (wait_q >= SL) ? SL : wait_q + 4'd1;
    unique case (state_q)
      PRI_CPU: begin
        burst_d = 4'd0;
        if (ext_starved && wait_d == SL)
          state_d = PRI_EXT;
      end
      PRI_EXT: begin
        if (!bus.ext_req) begin
          state_d = PRI_CPU;
          burst_d = 4'd0;
        end else if (ext_gnt) begin
          if (burst_q + 4'd1 >= MB) begin
            state_d = PRI_CPU;
            burst_d = 4'd0;
          end else begin
            burst_d = burst_q + 4'd1;
          end
        end
      end
    endcase
  end

  // rvalid is masked during reset so a read issued just
  // before reset never reports data.
  assign cpu_rv = rd_valid_q && !rd_owner_q && !rst_i;
  assign ext_rv = rd_valid_q &&  rd_owner_q && !rst_i;

  always_comb begin
    rd_valid_d = (cpu_gnt && !bus.cpu_we) ||
                 (ext_gnt && !bus.ext_we);
    rd_owner_d = ext_gnt;
    cpu_hold_d = cpu_rv ? bus.mem_rdata : cpu_hold_q;
    ext_hold_d = ext_rv ? bus.mem_rdata : ext_hold_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= PRI_CPU;
      wait_q     <= 4'd0;
      burst_q    <= 4'd0;
      rd_valid_q <= 1'b0;
      rd_owner_q <= 1'b0;
      cpu_hold_q <= 16'h0;
      ext_hold_q <= 16'h0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      burst_q    <= burst_d;
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
      cpu_hold_q <= cpu_hold_d;
      ext_hold_q <= ext_hold_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.ext_gnt    = ext_gnt;
  assign bus.cpu_stall  = bus.cpu_req && !cpu_gnt && !rst_i;
  assign bus.cpu_rvalid = cpu_rv;
  assign bus.ext_rvalid = ext_rv;
  assign bus.cpu_rdata  = cpu_rv ? bus.mem_rdata : cpu_hold_q;
  assign bus.ext_rdata  = ext_rv ? bus.mem_rdata : ext_hold_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a read-data scoreboard.
// Memory model is a 256-word array indexed by address[7:0].
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        port;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];

  logic [15:0] mem [0:255];
  logic mem_init = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(
    .STARVE_LIMIT (3),
    .EXT_MAX_BURST(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  function automatic logic [15:0] pat(input logic [7:0] a);
    return {a, ~a};
  endfunction

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
      mem[8'h10] <= 16'hBEEF;
      mem[8'h11] <= 16'h1234;
      mem_init <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end
  end

  task automatic set_cpu(input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
    bus.cpu_req = r; bus.cpu_we = w;
    bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_ext(input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
    bus.ext_req = r; bus.ext_we = w;
    bus.ext_addr = a; bus.ext_wdata = d;
  endtask

  task automatic idle();
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    set_ext(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard pop: every read grant pushed last cycle must show up now.
  task automatic smp();
    exp_t e;
    logic gp;
    logic [15:0] gd;
    @(negedge clk);
    if (bus.cpu_rvalid === 1'b1 || bus.ext_rvalid === 1'b1) begin
      checks++;
      gp = bus.ext_rvalid;
      gd = gp ? bus.ext_rdata : bus.cpu_rdata;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rvalid_extra cpu_rv=%b ext_rv=%b want none",
                 bus.cpu_rvalid, bus.ext_rvalid);
      end else begin
        e = sb.pop_front();
        if ((bus.cpu_rvalid && bus.ext_rvalid) ||
            gp !== e.port || gd !== e.data) begin
          failures++;
          $display("FAIL rdata port=%b data=%h want port=%b data=%h",
                   gp, gd, e.port, e.data);
        end
      end
    end else if (sb.size() != 0) begin
      checks++;
      failures++;
      e = sb.pop_front();
      $display("FAIL rvalid_missing got none want port=%b data=%h",
               e.port, e.data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_cpu(1'b1, 1'b0, 16'h10, 16'h0);
    set_ext(1'b1, 1'b0, 16'h40, 16'h0);
    repeat (2) begin
      smp();
      checks++;
      if ({bus.cpu_gnt, bus.ext_gnt, bus.mem_en, bus.cpu_stall}
          !== 4'b0000) begin
        failures++;
        $display("FAIL rst_outputs got %b%b%b%b want 0000",
                 bus.cpu_gnt, bus.ext_gnt, bus.mem_en, bus.cpu_stall);
      end
      nxt();
    end
    rst = 1'b0;
    idle();
    smp();
    checks++;
    if ({bus.cpu_rvalid, bus.ext_rvalid, bus.cpu_rdata, bus.ext_rdata}
        !== 34'h0) begin
      failures++;
      $display("FAIL rst_read_state rv=%b%b cd=%h ed=%h want 0",
               bus.cpu_rvalid, bus.ext_rvalid,
               bus.cpu_rdata, bus.ext_rdata);
    end
    nxt();
  endtask

  task automatic test_cpu_reads();
    logic [15:0] ad [2];
    logic [15:0] dv [2];
    ad[0] = 16'h0010; ad[1] = 16'h0011;
    dv[0] = 16'hBEEF; dv[1] = 16'h1234;
    for (int k = 0; k < 2; k++) begin
      set_cpu(1'b1, 1'b0, ad[k], 16'h0);
      set_ext(1'b0, 1'b0, 16'h0, 16'h0);
      smp();
      checks++;
      if ({bus.cpu_gnt, bus.cpu_stall, bus.mem_en, bus.mem_we,
           bus.mem_addr} !== {4'b1010, ad[k]}) begin
        failures++;
        $display("FAIL cpu_read_issue g=%b s=%b en=%b we=%b a=%h want a=%h",
                 bus.cpu_gnt, bus.cpu_stall, bus.mem_en, bus.mem_we,
                 bus.mem_addr, ad[k]);
      end
      sb.push_back({1'b0, dv[k]});
      nxt();
    end
    idle();
    repeat (2) begin smp(); nxt(); end
    smp();
    checks++;
    if (bus.cpu_rdata !== 16'h1234) begin
      failures++;
      $display("FAIL cpu_rdata_hold got %h want 1234", bus.cpu_rdata);
    end
    nxt();
  endtask

  task automatic test_contend();
    logic [15:0] ca;
    logic [15:0] ea;
    logic ec;
    ca = 16'h0020;
    ea = 16'h0040;
    for (int k = 0; k < 10; k++) begin
      set_cpu(1'b1, 1'b0, ca, 16'h0);
      set_ext(1'b1, 1'b0, ea, 16'h0);
      smp();
      ec = (k % 5) < 3;
      checks++;
      if ({bus.cpu_gnt, bus.ext_gnt, bus.cpu_stall} !== {ec, ~ec, ~ec}) begin
        failures++;
        $display("FAIL contend_gnt k=%0d cg=%b eg=%b st=%b want cg=%b",
                 k, bus.cpu_gnt, bus.ext_gnt, bus.cpu_stall, ec);
      end
      if (ec) begin
        sb.push_back({1'b0, pat(ca[7:0])});
        ca = ca + 16'h1;
      end else begin
        sb.push_back({1'b1, pat(ea[7:0])});
        ea = ea + 16'h1;
      end
      nxt();
    end
    idle();
    smp();
    nxt();
  endtask

  task automatic test_ext_write_fwd();
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    set_ext(1'b1, 1'b1, 16'h0100, 16'h00AA);
    smp();
    checks++;
    if ({bus.ext_gnt, bus.cpu_gnt, bus.mem_en, bus.mem_we,
         bus.mem_addr, bus.mem_wdata} !== {4'b1011, 16'h0100, 16'h00AA}) begin
      failures++;
      $display("FAIL ext_write g=%b%b en=%b we=%b a=%h d=%h want 1011 0100 00aa",
               bus.ext_gnt, bus.cpu_gnt, bus.mem_en, bus.mem_we,
               bus.mem_addr, bus.mem_wdata);
    end
    nxt();
    set_ext(1'b0, 1'b0, 16'h0, 16'h0);
    set_cpu(1'b1, 1'b0, 16'h0100, 16'h0);
    smp();
    checks++;
    if (bus.cpu_gnt !== 1'b1) begin
      failures++;
      $display("FAIL fwd_read_gnt got %b want 1", bus.cpu_gnt);
    end
    sb.push_back({1'b0, 16'h00AA});
    nxt();
    idle();
    smp();
    nxt();
  endtask

  task automatic test_ext_drop();
    logic [15:0] ca;
    logic ec;
    ca = 16'h0030;
    for (int k = 0; k < 6; k++) begin
      set_cpu(1'b1, 1'b0, ca, 16'h0);
      if (k == 4) set_ext(1'b0, 1'b0, 16'h0, 16'h0);
      else set_ext(1'b1, 1'b0, (k == 5) ? 16'h0051 : 16'h0050, 16'h0);
      smp();
      ec = (k != 3);
      checks++;
      if ({bus.cpu_gnt, bus.ext_gnt} !== {ec, ~ec & (k != 4)}) begin
        failures++;
        $display("FAIL drop_gnt k=%0d cg=%b eg=%b want cg=%b",
                 k, bus.cpu_gnt, bus.ext_gnt, ec);
      end
      if (ec) begin
        sb.push_back({1'b0, pat(ca[7:0])});
        ca = ca + 16'h1;
      end else begin
        sb.push_back({1'b1, pat(8'h50)});
      end
      nxt();
    end
    idle();
    smp();
    nxt();
  endtask

  task automatic test_reset_mid();
    logic [15:0] ca;
    logic [15:0] ea;
    logic ec;
    ca = 16'h0060;
    ea = 16'h0070;
    for (int k = 0; k < 2; k++) begin
      set_cpu(1'b1, 1'b0, ca, 16'h0);
      set_ext(1'b1, 1'b0, ea, 16'h0);
      smp();
      checks++;
      if ({bus.cpu_gnt, bus.ext_gnt} !== 2'b10) begin
        failures++;
        $display("FAIL pre_rst_gnt k=%0d got %b%b want 10",
                 k, bus.cpu_gnt, bus.ext_gnt);
      end
      if (k == 0) sb.push_back({1'b0, pat(ca[7:0])});
      ca = ca + 16'h1;
      nxt();
    end
    rst = 1'b1;
    smp();
    checks++;
    if ({bus.cpu_gnt, bus.ext_gnt, bus.mem_en, bus.cpu_stall,
         bus.cpu_rvalid} !== 5'b0) begin
      failures++;
      $display("FAIL mid_rst g=%b%b en=%b st=%b rv=%b want 0",
               bus.cpu_gnt, bus.ext_gnt, bus.mem_en, bus.cpu_stall,
               bus.cpu_rvalid);
    end
    nxt();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_cpu(1'b1, 1'b0, ca, 16'h0);
      set_ext(1'b1, 1'b0, ea, 16'h0);
      smp();
      ec = (k < 3);
      checks++;
      if ({bus.cpu_gnt, bus.ext_gnt} !== {ec, ~ec}) begin
        failures++;
        $display("FAIL post_rst_gnt k=%0d got %b%b want cg=%b",
                 k, bus.cpu_gnt, bus.ext_gnt, ec);
      end
      if (ec) begin
        sb.push_back({1'b0, pat(ca[7:0])});
        ca = ca + 16'h1;
      end else begin
        sb.push_back({1'b1, pat(ea[7:0])});
        ea = ea + 16'h1;
      end
      nxt();
    end
    idle();
    smp();
    nxt();
  endtask

  task automatic test_write_contest();
    logic [15:0] ca;
    ca = 16'h0080;
    for (int k = 0; k < 4; k++) begin
      set_cpu(1'b1, 1'b1, ca, 16'hC000 + ca - 16'h0080);
      set_ext(1'b1, 1'b1, 16'h0090, 16'h0E0E);
      smp();
      checks++;
      if (k < 3) begin
        if ({bus.cpu_gnt, bus.ext_gnt, bus.mem_we, bus.mem_addr,
             bus.mem_wdata} !== {3'b101, ca, 16'hC000 + 16'(k)}) begin
          failures++;
          $display("FAIL wr_cpu k=%0d g=%b%b we=%b a=%h d=%h want cpu",
                   k, bus.cpu_gnt, bus.ext_gnt, bus.mem_we,
                   bus.mem_addr, bus.mem_wdata);
        end
        ca = ca + 16'h1;
      end else begin
        if ({bus.cpu_gnt, bus.ext_gnt, bus.cpu_stall, bus.mem_we,
             bus.mem_addr, bus.mem_wdata}
            !== {4'b0111, 16'h0090, 16'h0E0E}) begin
          failures++;
          $display("FAIL wr_ext g=%b%b st=%b we=%b a=%h d=%h want ext",
                   bus.cpu_gnt, bus.ext_gnt, bus.cpu_stall, bus.mem_we,
                   bus.mem_addr, bus.mem_wdata);
        end
      end
      nxt();
    end
    idle();
    smp();
    nxt();
    set_cpu(1'b1, 1'b0, 16'h0090, 16'h0);
    smp();
    sb.push_back({1'b0, 16'h0E0E});
    nxt();
    set_cpu(1'b1, 1'b0, 16'h0080, 16'h0);
    smp();
    sb.push_back({1'b0, 16'hC000});
    nxt();
    idle();
    repeat (2) begin smp(); nxt(); end
  endtask

  initial begin
    idle();
    bus.mem_rdata = 16'h0;
    test_reset();
    test_cpu_reads();
    test_contend();
    test_ext_write_fwd();
    test_ext_drop();
    test_reset_mid();
    test_write_contest();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain left=%0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
